// File: rtl/game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_ctrl_pkg
//   Shared types and default constants for the game sequencer.
//   - game_state_t : top-level game FSM encoding
//   - speed_t      : horizontal speed, Q5.10 pixels per frame
//   - DEFAULT_*    : default parameter values used by game_ctrl / speed_ramp
// -----------------------------------------------------------------------------
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        CRASHED = 2'd2
    } game_state_t;

    typedef logic [14:0] speed_t;

    localparam int SPEED_FRAC_BITS = 10;

    // Distance accumulator is Q16.10: 16 integer pixel bits + speed fraction.
    localparam int DIST_INT_BITS = 16;
    localparam int DIST_ACC_BITS = DIST_INT_BITS + SPEED_FRAC_BITS;

    localparam int DEFAULT_FPS            = 60;
    localparam int DEFAULT_SPEED_INIT     = 6144;   // 6.0 px/frame
    localparam int DEFAULT_SPEED_MAX      = 13312;  // 13.0 px/frame
    localparam int DEFAULT_ACCEL          = 1;
    localparam int DEFAULT_CLEAR_FRAMES   = 180;
    localparam int DEFAULT_RESTART_FRAMES = 45;

endpackage

// File: rtl/game_ctrl_speed_ramp.sv
// -----------------------------------------------------------------------------
// speed_ramp
//   Speed and distance accumulators for the running game.
//   load     : reinitialise speed to SPEED_INIT and clear distance (game start)
//   step     : one running frame: distance += speed, speed += ACCEL (both
//              saturating); distance uses the speed value from before the step
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   load, step control strobes (load has priority)
//   speed      current speed, Q5.10
//   distance   integer part of the Q16.10 distance accumulator
// -----------------------------------------------------------------------------
module speed_ramp
    import game_ctrl_pkg::*;
#(
    parameter int SPEED_INIT = DEFAULT_SPEED_INIT,
    parameter int SPEED_MAX  = DEFAULT_SPEED_MAX,
    parameter int ACCEL      = DEFAULT_ACCEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [14:0] speed,
    output logic [15:0] distance
);

    localparam speed_t SPEED_INIT_V = speed_t'(SPEED_INIT);
    localparam speed_t SPEED_MAX_V  = speed_t'(SPEED_MAX);
    localparam int     ACC_SUM_W    = DIST_ACC_BITS + 1;

    logic [15:0]              speed_sum;
    speed_t                   speed_next;
    logic [ACC_SUM_W-1:0]     acc_sum;
    logic [DIST_ACC_BITS-1:0] acc;
    logic [DIST_ACC_BITS-1:0] acc_next;

    // One spare bit on each adder catches the overflow used for saturation.
    always_comb begin
        speed_sum  = {1'b0, speed} + 16'(ACCEL);
        speed_next = (speed_sum > {1'b0, SPEED_MAX_V}) ? SPEED_MAX_V : speed_sum[14:0];
        acc_sum    = {1'b0, acc} + ACC_SUM_W'(speed);
        acc_next   = acc_sum[ACC_SUM_W-1] ? '1 : acc_sum[DIST_ACC_BITS-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed <= SPEED_INIT_V;
            acc   <= '0;
        end else if (load) begin
            speed <= SPEED_INIT_V;
            acc   <= '0;
        end else if (step) begin
            speed <= speed_next;
            acc   <= acc_next;
        end
    end

    // A saturated accumulator is all ones, so the integer part pins at 0xFFFF.
    assign distance = acc[DIST_ACC_BITS-1:SPEED_FRAC_BITS];

endmodule

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
//   Top-level game sequencer: turns the frame tick into update/timer strobes,
//   runs the IDLE -> RUNNING -> CRASHED -> RUNNING game FSM, gates obstacle
//   spawning after a clear period, enforces a restart lockout after a crash
//   and drives the PRNG seed hold.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   frame_tick     1-cycle pulse per video frame
//   jump           1-cycle debounced jump/start pulse
//   collision      level, collision detected this cycle
//   update         1-cycle per-frame advance strobe (RUNNING only)
//   timer          free-running frame counter 0..FPS-1
//   start          1-cycle pulse on game (re)start
//   crash          high while CRASHED
//   speed          current speed, Q5.10
//   has_obstacles  obstacle spawning enabled
//   rng_load       hold PRNG at seed (IDLE only)
//   distance       integer pixels run, saturating
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int FPS            = DEFAULT_FPS,
    parameter int SPEED_INIT     = DEFAULT_SPEED_INIT,
    parameter int SPEED_MAX      = DEFAULT_SPEED_MAX,
    parameter int ACCEL          = DEFAULT_ACCEL,
    parameter int CLEAR_FRAMES   = DEFAULT_CLEAR_FRAMES,
    parameter int RESTART_FRAMES = DEFAULT_RESTART_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        jump,
    input  logic        collision,
    output logic        update,
    output logic [5:0]  timer,
    output logic        start,
    output logic        crash,
    output logic [14:0] speed,
    output logic        has_obstacles,
    output logic        rng_load,
    output logic [15:0] distance
);

    localparam int CLR_W = $clog2(CLEAR_FRAMES + 1);
    localparam int RST_W = $clog2(RESTART_FRAMES + 1);

    localparam logic [5:0]       TIMER_LAST  = 6'(FPS - 1);
    localparam logic [CLR_W-1:0] CLEAR_MAX   = CLR_W'(CLEAR_FRAMES);
    localparam logic [RST_W-1:0] RESTART_MAX = RST_W'(RESTART_FRAMES);

    game_state_t      state;
    game_state_t      state_next;
    logic [CLR_W-1:0] clear_cnt;
    logic [CLR_W-1:0] clear_cnt_inc;
    logic [RST_W-1:0] restart_cnt;

    logic start_go;   // game (re)starts at this edge
    logic crash_go;   // collision ends the run at this edge
    logic adv;        // running frame advances at this edge

    logic start_d;
    logic update_d;
    logic crash_d;
    logic rng_load_d;

    // Collision outranks a coincident frame tick; jump only acts outside
    // RUNNING, so it is naturally ignored on a crash edge.
    assign start_go = jump && ((state == IDLE) ||
                               (state == CRASHED && restart_cnt == RESTART_MAX));
    assign crash_go = (state == RUNNING) && collision;
    assign adv      = (state == RUNNING) && frame_tick && !collision;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            start    <= 1'b0;
            update   <= 1'b0;
            crash    <= 1'b0;
            rng_load <= 1'b1;
        end else begin
            state    <= state_next;
            start    <= start_d;
            update   <= update_d;
            crash    <= crash_d;
            rng_load <= rng_load_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment up front so no path through the case
        // leaves state_next unassigned (which would infer a latch).
        state_next = state;
        case (state)
            IDLE:    if (start_go) state_next = RUNNING;
            RUNNING: if (crash_go) state_next = CRASHED;
            CRASHED: if (start_go) state_next = RUNNING;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // start_go and adv are mutually exclusive by state, so start and update
    // can never be high together.
    always_comb begin
        start_d    = start_go;
        update_d   = adv;
        crash_d    = (state_next == CRASHED);
        rng_load_d = (state_next == IDLE);
    end

    // ----------------------------------------------------------------- counters
    assign clear_cnt_inc = (clear_cnt == CLEAR_MAX) ? clear_cnt : clear_cnt + CLR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer         <= '0;
            clear_cnt     <= '0;
            restart_cnt   <= '0;
            has_obstacles <= 1'b0;
        end else begin
            if (frame_tick) begin
                timer <= (timer == TIMER_LAST) ? '0 : timer + 6'd1;
            end

            if (start_go) begin
                clear_cnt     <= '0;
                has_obstacles <= 1'b0;
            end else if (adv) begin
                clear_cnt <= clear_cnt_inc;
                if (clear_cnt_inc == CLEAR_MAX) begin
                    has_obstacles <= 1'b1;
                end
            end

            if (crash_go) begin
                restart_cnt <= '0;
            end else if (state == CRASHED && frame_tick && restart_cnt != RESTART_MAX) begin
                restart_cnt <= restart_cnt + RST_W'(1);
            end
        end
    end

    // ------------------------------------------------------- speed and distance
    speed_ramp #(
        .SPEED_INIT (SPEED_INIT),
        .SPEED_MAX  (SPEED_MAX),
        .ACCEL      (ACCEL)
    ) u_speed_ramp (
        .clk      (clk),
        .rst      (rst),
        .load     (start_go),
        .step     (adv),
        .speed    (speed),
        .distance (distance)
    );

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
//   Directed bench for game_ctrl. Inputs change and outputs are sampled 3 time
//   units after each rising edge; pulse/overlap monitors count on the falling
//   edge. Expected values are hand-computed constants; the only model is the
//   expected frame timer.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        jump;
    logic        collision;
    logic        update;
    logic [5:0]  timer;
    logic        start;
    logic        crash;
    logic [14:0] speed;
    logic        has_obstacles;
    logic        rng_load;
    logic [15:0] distance;

    int checks    = 0;
    int errors    = 0;
    int upd_cnt   = 0;
    int start_cnt = 0;
    int overlap   = 0;
    int exp_timer = 0;
    int t_saved;

    game_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .jump          (jump),
        .collision     (collision),
        .update        (update),
        .timer         (timer),
        .start         (start),
        .crash         (crash),
        .speed         (speed),
        .has_obstacles (has_obstacles),
        .rng_load      (rng_load),
        .distance      (distance)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update)          upd_cnt++;
        if (start)           start_cnt++;
        if (start && update) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 3 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // One frame_tick sampled at the next edge; returns in the cycle after it.
    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        exp_timer  = (exp_timer == 59) ? 0 : exp_timer + 1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            step();
        end
    endtask

    task automatic jump_pulse();
        jump = 1'b1;
        step();
        jump = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, " timer"},    32'(timer),         0);
        check({pfx, " update"},   32'(update),        0);
        check({pfx, " start"},    32'(start),         0);
        check({pfx, " crash"},    32'(crash),         0);
        check({pfx, " speed"},    32'(speed),         6144);
        check({pfx, " has_obs"},  32'(has_obstacles), 0);
        check({pfx, " rng_load"}, 32'(rng_load),      1);
        check({pfx, " distance"}, 32'(distance),      0);
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        jump       = 1'b0;
        collision  = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();

        // 1. idle: timer runs, nothing else moves
        frames(3);
        check("idle timer",    32'(timer),    3);
        check("idle updates",  32'(upd_cnt),  0);
        check("idle rng_load", 32'(rng_load), 1);
        check("idle speed",    32'(speed),    6144);
        check("idle starts",   32'(start_cnt), 0);

        // 2. start from IDLE, first running frame
        jump_pulse();
        check("start pulse",     32'(start),    1);
        check("start rng_load",  32'(rng_load), 0);
        check("start crash",     32'(crash),    0);
        step();
        check("start one cycle", 32'(start),     0);
        check("start count",     32'(start_cnt), 1);
        tick();
        check("first update",    32'(update),   1);
        check("first speed",     32'(speed),    6145);
        check("first distance",  32'(distance), 6);
        step();
        check("update one cycle", 32'(update),  0);
        check("update count",     32'(upd_cnt), 1);

        // 3. obstacle clear time: rises with the 180th update
        frames(178);
        check("clear 179 has_obs", 32'(has_obstacles), 0);
        check("clear 179 speed",   32'(speed),         6323);
        tick();
        check("clear 180 update",   32'(update),        1);
        check("clear 180 has_obs",  32'(has_obstacles), 1);
        check("clear 180 speed",    32'(speed),         6324);
        check("clear 180 distance", 32'(distance),      1095);
        step();
        check("clear 180 count",    32'(upd_cnt), 180);

        // 4. crash on the same edge as a frame tick
        collision  = 1'b1;
        frame_tick = 1'b1;
        step();
        collision  = 1'b0;
        frame_tick = 1'b0;
        exp_timer  = (exp_timer == 59) ? 0 : exp_timer + 1;
        check("crash level",    32'(crash),         1);
        check("crash no upd",   32'(update),        0);
        check("crash speed",    32'(speed),         6324);
        check("crash distance", 32'(distance),      1095);
        check("crash has_obs",  32'(has_obstacles), 1);
        check("crash rng_load", 32'(rng_load),      0);
        step();
        check("crash upd count", 32'(upd_cnt), 180);

        frames(10);
        jump_pulse();
        check("lockout 10 start", 32'(start), 0);
        check("lockout 10 crash", 32'(crash), 1);
        check("lockout speed",    32'(speed), 6324);
        check("lockout updates",  32'(upd_cnt), 180);
        frames(34);
        jump_pulse();
        check("lockout 44 start", 32'(start), 0);
        check("lockout 44 crash", 32'(crash), 1);
        frames(1);
        jump_pulse();
        check("restart start",    32'(start),         1);
        check("restart crash",    32'(crash),         0);
        check("restart speed",    32'(speed),         6144);
        check("restart distance", 32'(distance),      0);
        check("restart has_obs",  32'(has_obstacles), 0);
        check("restart rng_load", 32'(rng_load),      0);
        step();
        check("restart count",    32'(start_cnt), 2);

        // speed ramp and saturation
        frames(1000);
        check("ramp 1000 speed",    32'(speed),    7144);
        check("ramp 1000 distance", 32'(distance), 6487);
        frames(6167);
        check("ramp 7167 speed",    32'(speed),    13311);
        check("ramp 7167 distance", 32'(distance), 16'hFFFF);
        tick();
        check("ramp 7168 speed",    32'(speed),    13312);
        check("ramp 7168 distance", 32'(distance), 16'hFFFF);
        step();
        frames(5);
        check("ramp sat speed",     32'(speed),         13312);
        check("ramp sat distance",  32'(distance),      16'hFFFF);
        check("ramp has_obs",       32'(has_obstacles), 1);
        check("ramp update count",  32'(upd_cnt),       7353);

        // 5. timer wrap after 60 ticks
        t_saved = exp_timer;
        check("timer model",   32'(timer), 32'(exp_timer));
        frames(60);
        check("timer wrap 60", 32'(timer), 32'(t_saved));

        // async reset mid-RUNNING while an update is in flight
        tick();
        check("pre-rst update", 32'(update), 1);
        rst = 1'b1;
        #1;
        check_reset_values("async rst");
        step();
        step();
        rst = 1'b0;
        exp_timer = 0;
        step();
        step();
        step();
        check("post-rst start",    32'(start),     0);
        check("post-rst starts",   32'(start_cnt), 2);
        check("post-rst rng_load", 32'(rng_load),  1);
        check("post-rst crash",    32'(crash),     0);

        check("start/update overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
